// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
//   imem_req_*  : valid/ready request carrying a word address
//   imem_resp_* : valid-only response, returned in request order
//   out_*       : {pc, instr} to decode with valid/ready handshake
// master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, issues in-order word requests to instruction
// memory, buffers returned words with their PC and hands {pc, instr} to decode.
// Branch/jump redirects flush the buffer and squash in-flight responses; the
// ECALL halt flag from decode stops the unit until reset.
// Ports:
//   clk, reset      : clock (rising edge), async active-low reset
//   bus (master)    : imem request/response and decode output handshakes
//   redirect_valid  : taken branch/JAL/JALR this cycle, target redirect_pc
//   halt            : decode says the instruction on out_* halts the core
//   halted          : sticky halt indicator
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  instruction_fetch_unit_if.master         bus,
  input  logic                             redirect_valid,
  input  logic [31:0]                      redirect_pc,
  input  logic                             halt,
  output logic                             halted
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state, state_nxt;
  logic [31:0]   fetch_pc, resp_pc, tgt_pc;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  entry_t        fifo_mem [FIFO_DEPTH];

  logic req_valid, out_valid, credit;
  logic issue, resp, pop, push, redir, halt_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit: words in flight plus words buffered never exceed the buffer size,
  // so every response has a slot. Registered values only, no same-cycle pop.
  assign credit = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W;
  assign tgt_pc = redirect_pc & 32'hFFFF_FFFC;

  // Next state and handshake qualifiers
  always_comb begin
    state_nxt = state;
    // reset gates the request so nothing is presented while held in reset
    req_valid = reset && (state == RUN) && credit;
    out_valid = (fifo_count != '0) && (state == RUN);
    issue     = req_valid && bus.imem_req_ready;
    resp      = bus.imem_resp_valid;
    pop       = out_valid && bus.out_ready;
    halt_fire = halt && pop;
    // halt wins over a redirect in the same cycle
    redir     = redirect_valid && (state == RUN) && !halt_fire;
    push      = resp && (state == RUN) && !redir && (drop_cnt == '0);
    if (state == RUN && halt_fire)
      state_nxt = HALT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // PCs and request/drop bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (redir) begin
        fetch_pc <= tgt_pc;
        resp_pc  <= tgt_pc;
        // everything still owed by memory after this edge is old-path;
        // a same-cycle response is already discarded via !redir on push
        drop_cnt <= outstanding + CW'(issue) - CW'(resp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // Instruction buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (redir) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{pc: resp_pc, instr: bus.imem_resp_data};
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = fifo_mem[rd_ptr].pc;
  assign bus.out_instr      = fifo_mem[rd_ptr].instr;
  assign halted             = (state == HALT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle-exact vector table for reset,
// steady fetch and backpressure, plus sequences for redirect, halt, PC wrap,
// mid-operation reset and request stall. Memory returns addr ^ 0x13.
module tb_instruction_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // ---------------- memory model ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          hs_count = 0;
  logic        hs_fire = 1'b0, resp_taken = 1'b0;
  logic [31:0] hs_addr = '0;

  always @(negedge clk) begin
    hs_fire    = bus.imem_req_valid && bus.imem_req_ready;
    hs_addr    = bus.imem_req_addr;
    resp_taken = bus.imem_resp_valid;
  end

  always @(posedge clk) begin
    cyc++;
    if (!reset) mq.delete();
    else begin
      if (resp_taken && mq.size() > 0) void'(mq.pop_front());
      if (hs_fire) begin
        mq.push_back('{addr: hs_addr, due: cyc + mem_lat - 1});
        hs_count++;
      end
    end
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mq[0].addr ^ 32'h13;
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
  end

  // credit rule must keep pushes off a full buffer
  always @(negedge clk) begin
    if (reset && dut.push && dut.fifo_count == DEPTH) begin
      vecs++; errs++;
      $display("FAIL push_full: push while count=%0d, required no push", dut.fifo_count);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  // Returns at the negedge of the next cycle with out_valid high.
  task automatic wait_out(input string name, output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1;
    end
    if (!found) begin
      vecs++; errs++;
      $display("FAIL %s: no out_valid within 40 cycles", name);
    end
  endtask

  task automatic expect_out(input logic [31:0] exp_pc, input string name);
    bit f;
    wait_out(name, f);
    if (f) begin
      chk({name, "_pc"},    bus.out_pc,    exp_pc);
      chk({name, "_instr"}, bus.out_instr, exp_pc ^ 32'h13);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          do_rst;
    bit          rdy;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_ov;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit rst, input bit rdy, input bit rv, input logic [31:0] a,
                     input bit ov, input logic [31:0] pc);
    vq.push_back('{do_rst: rst, rdy: rdy, exp_rv: rv, exp_addr: a, exp_ov: ov, exp_pc: pc});
  endtask

  initial begin
    bit f;
    int hs0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.out_ready       = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;

    // reset state while held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_req_addr",  bus.imem_req_addr,  32'h0);
    chk("rst_out_valid", bus.out_valid,      0);
    chk("rst_halted",    halted,             0);

    // T1: 1-cycle memory, decode always ready
    add(1, 1, 1, 32'h00, 0, 0);
    add(0, 1, 1, 32'h04, 0, 0);
    add(0, 1, 0, 32'h08, 1, 32'h0);
    add(0, 1, 1, 32'h08, 1, 32'h4);
    add(0, 1, 1, 32'h0C, 0, 0);
    add(0, 1, 0, 32'h10, 1, 32'h8);
    add(0, 1, 1, 32'h10, 1, 32'hC);
    // T2: decode stalled 10 cycles, then drains
    add(1, 0, 1, 32'h00, 0, 0);
    add(0, 0, 1, 32'h04, 0, 0);
    add(0, 0, 0, 32'h08, 1, 32'h0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 32'h08, 1, 32'h0);
    add(0, 1, 0, 32'h08, 1, 32'h0);
    add(0, 1, 1, 32'h08, 1, 32'h4);
    add(0, 1, 1, 32'h0C, 0, 0);
    add(0, 1, 0, 32'h10, 1, 32'h8);

    mem_lat = 1;
    hs0 = 0;
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].do_rst) reset_dut();
      else step();
      bus.out_ready = vq[i].rdy;
      if (i == 7) hs0 = hs_count;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {bus.imem_req_valid, bus.imem_req_addr},
          {vq[i].exp_rv, vq[i].exp_addr});
      chk($sformatf("v%0d_out", i), {bus.out_valid, bus.out_valid ? bus.out_pc : 32'h0},
          {vq[i].exp_ov, vq[i].exp_ov ? vq[i].exp_pc : 32'h0});
      if (i == 16) chk("t2_req_count", hs_count - hs0, 2);
    end

    // T3: redirect with two words in flight, 2-cycle memory
    mem_lat = 2;
    bus.out_ready = 1'b1;
    reset_dut();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    chk("t3_issue", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h4});
    step();
    redirect_valid = 1'b0;
    expect_out(32'h100, "t3_a");
    expect_out(32'h104, "t3_b");

    // T4: redirect coincident with response and accepted request
    mem_lat = 1;
    reset_dut();
    expect_out(32'h0, "t4_0");
    expect_out(32'h4, "t4_4");
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    chk("t4_coinc", {bus.imem_req_valid && bus.imem_req_ready, bus.imem_resp_valid}, 2'b11);
    step();
    redirect_valid = 1'b0;
    expect_out(32'h100, "t4_a");
    expect_out(32'h104, "t4_b");

    // T5: halt at pc 8 with a simultaneous redirect, late responses absorbed
    mem_lat = 3;
    reset_dut();
    expect_out(32'h0, "t5_0");
    expect_out(32'h4, "t5_4");
    wait_out("t5_8", f);
    if (f) begin
      chk("t5_8_pc", bus.out_pc, 32'h8);
      chk("t5_pre_halted", halted, 0);
      halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      step();
      halt = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk($sformatf("t5_halt_c%0d", i),
            {halted, bus.imem_req_valid, bus.out_valid}, 3'b100);
        step();
      end
      redirect_valid = 1'b0;
      chk("t5_outstanding", dut.outstanding, 0);
    end

    // T6: wrap at top of address space, then reset mid-burst
    mem_lat = 1;
    reset_dut();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    expect_out(32'hFFFF_FFFC, "t6_top");
    expect_out(32'h0, "t6_wrap");
    expect_out(32'h4, "t6_4");
    step();
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_outs", {bus.imem_req_valid, bus.out_valid, halted}, 3'b000);
    chk("t6_rst_addr", bus.imem_req_addr, 32'h0);
    chk("t6_rst_cnts", {dut.outstanding, dut.drop_cnt, dut.fifo_count}, 0);
    step(); step();
    reset = 1'b1;
    expect_out(32'h0, "t6_r0");
    expect_out(32'h4, "t6_r4");
    expect_out(32'h8, "t6_r8");

    // T7: request address held while memory stalls
    reset_dut();
    step();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t7_hold_c%0d", i), {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h4});
      step();
    end
    bus.imem_req_ready = 1'b1;
    expect_out(32'h4, "t7_4");
    expect_out(32'h8, "t7_8");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vecs);
    $fatal(1);
  end
endmodule
